// File: rtl/audio_vis_pkg.sv
// -----------------------------------------------------------------------------
// audio_vis_pkg
// Shared definitions for the audio visualiser front end (sample_framer and its
// sample_bank sub-module).
//   DEF_WIDTH / DEF_N : default sample width and frame length
//   wr_state_t        : write-side FSM states (FILL, PENDING)
//   rd_state_t        : read-side FSM states (IDLE, BUSY)
//   sample_t          : signed audio sample at the default width
// -----------------------------------------------------------------------------
package audio_vis_pkg;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_N     = 256;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } wr_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } rd_state_t;

    typedef logic signed [DEF_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sample_bank.sv
// -----------------------------------------------------------------------------
// sample_bank
// One N x WIDTH register bank: a single synchronous write port, a synchronous
// clear of every entry, and all N entries visible in parallel on dout.
// Ports:
//   clk  : clock
//   clr  : synchronous clear, zeroes every entry
//   we   : write enable
//   addr : write address (0..N-1)
//   din  : write data
//   dout : full parallel read of the bank
// -----------------------------------------------------------------------------
module sample_bank
    import audio_vis_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     we,
    input  logic [$clog2(N)-1:0]     addr,
    input  logic signed [WIDTH-1:0]  din,
    output logic signed [WIDTH-1:0]  dout [0:N-1]
);

    localparam int AW = $clog2(N);

    logic signed [WIDTH-1:0] r_mem [0:N-1];

    // Parallel read of every entry rules out a RAM macro, so each entry is
    // its own register with a decoded write enable.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (clr) begin
                    r_mem[gi] <= '0;
                end else if (we && (addr == AW'(gi))) begin
                    r_mem[gi] <= din;
                end
            end
            assign dout[gi] = r_mem[gi];
        end
    endgenerate

endmodule

// File: rtl/sample_framer.sv
// -----------------------------------------------------------------------------
// sample_framer
// Assembles a stream of signed samples into N-sample frames using two banks
// (ping-pong). The read bank is presented on time_samples and held stable while
// the downstream FFT runs; the other bank fills. A one-cycle fft_start pulse
// marks each new frame. Samples arriving while both banks are occupied are
// dropped and flagged.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   sample_in      : signed sample, qualified by sample_valid
//   sample_valid   : sample_in valid this cycle
//   fft_done       : done from the FFT (level or pulse; rising edge used)
//   time_samples   : read-bank contents, N entries
//   fft_start      : one-cycle start pulse for the FFT
//   fill_count     : samples held in the write bank (0..N)
//   overrun        : sticky, set when a valid sample is dropped
//   overrun_count  : saturating dropped-sample count
// Build option:
//   SAMPLE_FRAMER_OVERRUN_CNT_EN - when defined, overrun_count is an 8-bit
//   saturating counter; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module sample_framer
    import audio_vis_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [WIDTH-1:0]  sample_in,
    input  logic                     sample_valid,
    input  logic                     fft_done,
    output logic signed [WIDTH-1:0]  time_samples [0:N-1],
    output logic                     fft_start,
    output logic [$clog2(N):0]       fill_count,
    output logic                     overrun,
    output logic [7:0]               overrun_count
);

    localparam int            AW       = $clog2(N);
    localparam logic [AW:0]   LAST_IDX = (AW+1)'(N-1);

    wr_state_t   r_wr_state;
    rd_state_t   r_rd_state;
    logic        r_wr_sel;          // 0: write A / read B, 1: write B / read A
    logic [AW:0] r_wr_idx;          // counts up to N so it doubles as fill_count
    logic        r_done_q;
    logic        r_start;
    logic        r_overrun;

    logic        w_wr_fire;
    logic        w_drop;
    logic        w_full;
    logic        w_done_edge;
    logic        w_rd_idle;
    logic        w_swap;

    logic signed [WIDTH-1:0] w_bank_a [0:N-1];
    logic signed [WIDTH-1:0] w_bank_b [0:N-1];

    assign w_wr_fire   = sample_valid && (r_wr_state == FILL);
    assign w_drop      = sample_valid && (r_wr_state == PENDING);
    assign w_full      = (w_wr_fire && (r_wr_idx == LAST_IDX)) || (r_wr_state == PENDING);
    // A done edge coinciding with our own start pulse is a leftover level
    // from the previous frame, not completion of the new one.
    assign w_done_edge = fft_done && !r_done_q && !r_start;
    assign w_rd_idle   = (r_rd_state == IDLE) || w_done_edge;
    assign w_swap      = w_full && w_rd_idle;

    sample_bank #(.WIDTH(WIDTH), .N(N)) u_bank_a (
        .clk  (clk),
        .clr  (rst),
        .we   (w_wr_fire && !r_wr_sel),
        .addr (r_wr_idx[AW-1:0]),
        .din  (sample_in),
        .dout (w_bank_a)
    );

    sample_bank #(.WIDTH(WIDTH), .N(N)) u_bank_b (
        .clk  (clk),
        .clr  (rst),
        .we   (w_wr_fire && r_wr_sel),
        .addr (r_wr_idx[AW-1:0]),
        .din  (sample_in),
        .dout (w_bank_b)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rd_mux
            assign time_samples[gi] = r_wr_sel ? w_bank_a[gi] : w_bank_b[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= FILL;
            r_rd_state <= IDLE;
            r_wr_sel   <= 1'b0;
            r_wr_idx   <= '0;
            r_done_q   <= 1'b0;
            r_start    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_done_q <= fft_done;
            r_start  <= w_swap;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_swap) begin
                r_wr_sel   <= !r_wr_sel;
                r_wr_idx   <= '0;
                r_wr_state <= FILL;
                r_rd_state <= BUSY;
            end else begin
                if (w_wr_fire) begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                    if (r_wr_idx == LAST_IDX) begin
                        r_wr_state <= PENDING;
                    end
                end
                if (w_done_edge) begin
                    r_rd_state <= IDLE;
                end
            end
        end
    end

    assign fft_start  = r_start;
    assign fill_count = r_wr_idx;
    assign overrun    = r_overrun;

`ifdef SAMPLE_FRAMER_OVERRUN_CNT_EN
    logic [7:0] r_ovr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr_cnt <= '0;
        end else if (w_drop && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign overrun_count = r_ovr_cnt;
`else
    assign overrun_count = '0;
`endif

endmodule
